// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and elaboration helpers.
// Intended for reuse by the parametrised transmitter as well.
`timescale 1ns / 1ps
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop,
        StBreak
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Rounded division so the bit period error is at most half a clock.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Line front end: 2-FF synchroniser, bit-period counter and 3-tap majority voter centred
// on the middle of each bit.
`timescale 1ns / 1ps
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 278
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic restart,
    output logic s_din,
    output logic sample_strobe,
    output logic sample_bit,
    output logic bit_end
);

    localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TAP0     = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] TAP1     = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] TAP2     = CNT_W'(HALF + 1);

    logic             sync_q;
    logic             s_din_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tap0_q;
    logic             tap1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 1'b1;
            s_din_q <= 1'b1;
            cnt_q   <= '0;
            tap0_q  <= 1'b1;
            tap1_q  <= 1'b1;
        end else begin
            sync_q  <= din;
            s_din_q <= sync_q;
            if (restart || (cnt_q == CNT_LAST)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == TAP0) tap0_q <= s_din_q;
            if (cnt_q == TAP1) tap1_q <= s_din_q;
        end
    end

    // Third tap is the live synchronised value, so the vote is ready on the strobe cycle.
    assign s_din         = s_din_q;
    assign sample_strobe = (cnt_q == TAP2);
    assign sample_bit    = (tap0_q & tap1_q) | (tap0_q & s_din_q) | (tap1_q & s_din_q);
    assign bit_end       = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: framing FSM, LSB-first shift register, parity, framing and
// break detection on top of the majority-voting bit sampler.
`timescale 1ns / 1ps
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 32000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 brk,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned BIT_W        = clog2(DATA_BITS + 1);

    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_divisor
        $error("uart_rx_cfg: CLKS_PER_BIT must be at least 4");
    end

    rx_state_t            state_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_bit_q;
    logic                 stop_err_q;

    logic s_din;
    logic sample_strobe;
    logic sample_bit;
    logic bit_end;
    logic restart;

    // Counter is parked in IDLE, and in BREAK it only runs while the line is high.
    assign restart = (state_q == StIdle) || ((state_q == StBreak) && !s_din);

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .restart      (restart),
        .s_din        (s_din),
        .sample_strobe(sample_strobe),
        .sample_bit   (sample_bit),
        .bit_end      (bit_end)
    );

    logic par_xor;
    logic par_mismatch;
    logic stop_bad;
    logic is_break;

    always_comb begin
        par_xor      = (^shreg_q) ^ par_bit_q;
        par_mismatch = 1'b0;
        if (PARITY == PAR_ODD) begin
            par_mismatch = ~par_xor;
        end else if (PARITY == PAR_EVEN) begin
            par_mismatch = par_xor;
        end
        stop_bad = stop_err_q | ~sample_bit;
        // par_bit_q stays 0 without parity, so it never blocks break detection.
        is_break = stop_bad && (shreg_q == '0) && !par_bit_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_rx    <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            brk        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!s_din) state_q <= StStart;
                end
                StStart: begin
                    if (sample_strobe && sample_bit) begin
                        state_q <= StIdle;
                    end else begin
                        if (sample_strobe) begin
                            busy       <= 1'b1;
                            bit_cnt_q  <= '0;
                            par_bit_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                        end
                        if (bit_end) state_q <= StData;
                    end
                end
                StData: begin
                    if (sample_strobe) shreg_q <= {sample_bit, shreg_q[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != PAR_NONE) ? StPar : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StPar: begin
                    if (sample_strobe) par_bit_q <= sample_bit;
                    if (bit_end) state_q <= StStop;
                end
                StStop: begin
                    if (bit_end) bit_cnt_q <= bit_cnt_q + 1'b1;
                    // Completing at the final majority point leaves half a bit to resync.
                    if (sample_strobe) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            data_rx    <= shreg_q;
                            frame_err  <= stop_bad;
                            parity_err <= par_mismatch;
                            valid      <= 1'b1;
                            busy       <= 1'b0;
                            bit_cnt_q  <= '0;
                            if (is_break) begin
                                brk     <= 1'b1;
                                state_q <= StBreak;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else if (!sample_bit) begin
                            stop_err_q <= 1'b1;
                        end
                    end
                end
                StBreak: begin
                    if (s_din && bit_end) begin
                        brk     <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: a default 8N1 instance and a 7E2 instance driven with
// directed frames; per-instance monitors pop expected words on every valid pulse.
`timescale 1ns / 1ps
module tb_uart_rx_cfg;

    localparam real CLK_HALF = 15.625;
    localparam real CLK_NS   = 31.25;
    localparam real BIT_NS   = 8680.5;

    typedef struct packed {
        logic [8:0] data;
        logic       fe;
        logic       pe;
        logic       brk;
    } exp_t;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic din0 = 1'b1;
    logic din1 = 1'b1;

    logic [7:0] data_rx0;
    logic       valid0, frame_err0, parity_err0, brk0, busy0;
    logic [6:0] data_rx1;
    logic       valid1, frame_err1, parity_err1, brk1, busy1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    int      n_chk = 0;
    int      n_err = 0;
    bit      seen_valid0 = 1'b0;
    realtime t_first_valid0 = 0.0;

    always #(CLK_HALF) clk = ~clk;

    uart_rx_cfg u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .din       (din0),
        .data_rx   (data_rx0),
        .valid     (valid0),
        .frame_err (frame_err0),
        .parity_err(parity_err0),
        .brk       (brk0),
        .busy      (busy0)
    );

    uart_rx_cfg #(
        .DATA_BITS(7),
        .PARITY   (2),
        .STOP_BITS(2)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .din       (din1),
        .data_rx   (data_rx1),
        .valid     (valid1),
        .frame_err (frame_err1),
        .parity_err(parity_err1),
        .brk       (brk1),
        .busy      (busy1)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic void check_range(input string name, input real act, input real lo,
                                        input real hi);
        n_chk++;
        if (!(act >= lo && act <= hi)) begin
            n_err++;
            $display("FAIL %s: got %0.2f, required %0.2f..%0.2f", name, act, lo, hi);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && valid0) begin
            if (!seen_valid0) begin
                seen_valid0    = 1'b1;
                t_first_valid0 = $realtime - CLK_HALF;
            end
            if (q0.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_valid0: got data 0x%0h, required no valid", data_rx0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_data", 32'(data_rx0), 32'(e0.data));
                check("dut0_frame_err", 32'(frame_err0), 32'(e0.fe));
                check("dut0_parity_err", 32'(parity_err0), 32'(e0.pe));
                check("dut0_brk", 32'(brk0), 32'(e0.brk));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && valid1) begin
            if (q1.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_valid1: got data 0x%0h, required no valid", data_rx1);
            end else begin
                e1 = q1.pop_front();
                check("dut1_data", 32'(data_rx1), 32'(e1.data));
                check("dut1_frame_err", 32'(frame_err1), 32'(e1.fe));
                check("dut1_parity_err", 32'(parity_err1), 32'(e1.pe));
                check("dut1_brk", 32'(brk1), 32'(e1.brk));
            end
        end
    end

    task automatic drive(input int sel, input logic v);
        if (sel == 0) din0 = v;
        else din1 = v;
    endtask

    task automatic send_frame(input int sel, input int nbits, input logic [8:0] data,
                              input bit has_par, input logic par_val, input int nstop,
                              input logic stop_val);
        drive(sel, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]);
            #(BIT_NS);
        end
        if (has_par) begin
            drive(sel, par_val);
            #(BIT_NS);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(sel, stop_val);
            #(BIT_NS);
        end
        drive(sel, 1'b1);
    endtask

    initial begin
        #(2.0e6);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        realtime t_fall;
        realtime t_high;
        realtime t_brk;
        bit      found;

        #40.3;
        check("reset_outputs0",
              32'({data_rx0, valid0, frame_err0, parity_err0, brk0, busy0}), 32'h0);
        check("reset_outputs1",
              32'({data_rx1, valid1, frame_err1, parity_err1, brk1, busy1}), 32'h0);
        #60.0;
        rst = 1'b1;
        #(20 * CLK_NS);

        // Back-to-back 8N1 frames, first-frame latency measured from the start edge.
        q0.push_back('{data: 9'h02A, fe: 1'b0, pe: 1'b0, brk: 1'b0});
        q0.push_back('{data: 9'h058, fe: 1'b0, pe: 1'b0, brk: 1'b0});
        t_fall = $realtime;
        send_frame(0, 8, 9'h02A, 1'b0, 1'b0, 1, 1'b1);
        send_frame(0, 8, 9'h058, 1'b0, 1'b0, 1, 1'b1);
        #(2 * BIT_NS);
        check_range("latency_first_valid", (t_first_valid0 - t_fall) / CLK_NS, 2644.0, 2646.0);
        check("q0_drained_b2b", 32'(q0.size()), 32'd0);

        // 7E2: 0x41 has two ones, so the even parity bit is 0.
        q1.push_back('{data: 9'h041, fe: 1'b0, pe: 1'b0, brk: 1'b0});
        q1.push_back('{data: 9'h041, fe: 1'b0, pe: 1'b1, brk: 1'b0});
        send_frame(1, 7, 9'h041, 1'b1, 1'b0, 2, 1'b1);
        send_frame(1, 7, 9'h041, 1'b1, 1'b1, 2, 1'b1);
        #(2 * BIT_NS);
        check("q1_drained_parity", 32'(q1.size()), 32'd0);

        // Low stop bit on non-zero data: framing error but no break.
        q0.push_back('{data: 9'h055, fe: 1'b1, pe: 1'b0, brk: 1'b0});
        send_frame(0, 8, 9'h055, 1'b0, 1'b0, 0, 1'b1);
        din0 = 1'b0;
        #(0.6 * BIT_NS);
        din0 = 1'b1;
        #(3 * BIT_NS);
        check("q0_drained_frame_err", 32'(q0.size()), 32'd0);
        check("brk_after_frame_err", 32'(brk0), 32'd0);

        // Break: 15 bit times low, then release and time the brk fall.
        q0.push_back('{data: 9'h000, fe: 1'b1, pe: 1'b0, brk: 1'b1});
        din0 = 1'b0;
        #(15 * BIT_NS);
        check("brk_held_while_low", 32'(brk0), 32'd1);
        check("q0_drained_break", 32'(q0.size()), 32'd0);
        din0   = 1'b1;
        t_high = $realtime;
        found  = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (!brk0) found = 1'b1;
        end
        t_brk = found ? ($realtime - CLK_HALF) : (t_high + 1.0e6);
        check_range("brk_release_clocks", (t_brk - t_high) / CLK_NS, 278.0, 281.0);
        #(BIT_NS);
        q0.push_back('{data: 9'h0A5, fe: 1'b0, pe: 1'b0, brk: 1'b0});
        send_frame(0, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1);
        #(2 * BIT_NS);

        // 60-clock glitch must be rejected.
        din0 = 1'b0;
        #(60 * CLK_NS);
        din0 = 1'b1;
        #(2 * BIT_NS);
        check("busy_after_glitch", 32'(busy0), 32'd0);
        q0.push_back('{data: 9'h03C, fe: 1'b0, pe: 1'b0, brk: 1'b0});
        send_frame(0, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b1);
        #(2 * BIT_NS);
        check("data_held_after_frame", 32'(data_rx0), 32'h3C);

        // Reset during bit 4 of 0xFF aborts the frame.
        din0 = 1'b0;
        #(BIT_NS);
        din0 = 1'b1;
        #(4.5 * BIT_NS);
        check("busy_mid_frame", 32'(busy0), 32'd1);
        rst = 1'b0;
        #1.0;
        check("async_reset_outputs0",
              32'({data_rx0, valid0, frame_err0, parity_err0, brk0, busy0}), 32'h0);
        #(0.25 * BIT_NS);
        rst = 1'b1;
        #(4.25 * BIT_NS);
        #(2 * BIT_NS);
        check("busy_after_abort", 32'(busy0), 32'd0);
        q0.push_back('{data: 9'h081, fe: 1'b0, pe: 1'b0, brk: 1'b0});
        send_frame(0, 8, 9'h081, 1'b0, 1'b0, 1, 1'b1);
        #(2 * BIT_NS);

        check("q0_drained_final", 32'(q0.size()), 32'd0);
        check("q1_drained_final", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Deserialises an asynchronous serial line into DATA_BITS-wide words and supports configurable parity, stop bits and baud divisor. Adds glitch-rejecting start detection, 3-sample majority voting and framing, parity and break detection. Sits between the board RX pin and the transmitter or FIFO; its valid output can drive a transmitter enable directly, as in the echo path.

Parameters:
CLK_FREQ, 32000000, system clock frequency in Hz.
BAUD, 115200, line rate in baud; CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD, giving 278 at the defaults.
DATA_BITS, 8, payload bits per frame, legal range 5..9, sent LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
din  in  1  raw serial line; idles high; asynchronous to clk.
data_rx  out  DATA_BITS  last received word; held until the next valid.
valid  out  1  single-cycle pulse when a frame completes, including errored frames.
frame_err  out  1  qualifies valid: a stop bit was sampled low.
parity_err  out  1  qualifies valid: parity mismatch; always 0 when PARITY=0.
brk  out  1  high while a break condition is active.
busy  out  1  high from the validated start edge until return to IDLE.

Behaviour:
- Reset (rst low, asynchronous): FSM goes to IDLE; data_rx=0, valid=0, frame_err=0, parity_err=0, brk=0, busy=0; bit and clock counters cleared; both synchroniser flops set to 1.
- din passes through a 2-FF synchroniser; all logic uses the synchronised value s_din.
- Majority sample of a bit: s_din taken at bit-clock counts CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1; the bit value is 2-of-3. The bit counter restarts at 0 on each bit boundary.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: on s_din=0, go to START and clear the clock counter.
- START: at the majority point, a result of 1 is a glitch and returns to IDLE with no output; a result of 0 sets busy and goes to DATA at the end of the bit.
- DATA: shift in DATA_BITS bits LSB first. After the last bit, go to PAR if PARITY!=0, otherwise to STOP.
- PAR: odd mode requires the XOR of data and the parity bit to be 1; even mode requires it to be 0. Record the mismatch.
- STOP: sample STOP_BITS stop bits. Any stop bit sampled 0 sets frame_err. The frame completes at the majority point of the final stop bit, not at the end of that bit, which allows resync to a back-to-back start.
- Completion timing: in the cycle after the final majority decision, data_rx, frame_err and parity_err update, valid=1 for exactly one clock, and the FSM goes to IDLE.
- Error flags are cleared on the next valid; they are not sticky across frames.
- Break: if frame_err=1 and all data bits are 0 (and the parity bit is 0 when present), assert brk and go to BREAK instead of IDLE. Stay in BREAK until s_din has been 1 for one full CLKS_PER_BIT, then clear brk and return to IDLE. No start detection happens in BREAK.
- A start edge arriving in the same cycle as completion is seen in the next IDLE cycle. The maximum added latency is 1 clock, which stays within the majority window.
- Latency from the din falling edge to valid: 2 (synchroniser) + (1 + DATA_BITS + parity bit + STOP_BITS - 1) * CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 (third sample) + 1 (register) clocks. At defaults, 8N1: 2 + 9*278 + 139 + 2 = 2645.
- Reset asserted mid-frame aborts the frame with no valid pulse. After release, reception resumes only at a new start edge.
- Width rules: the clock counter is clog2(CLKS_PER_BIT) bits; the bit counter is clog2(DATA_BITS+1) bits. Elaboration fails if DATA_BITS, PARITY or STOP_BITS is out of range, or if CLKS_PER_BIT < 4.

Decomposition:
- uart_pkg holds:
  - the rx state typedef;
  - the parity mode constants PAR_NONE, PAR_ODD and PAR_EVEN;
  - the function clks_per_bit(clk_freq, baud);
  - the function clog2.
- The pkg is shared with the planned parametrised transmitter.
- One sub-module, uart_bit_sampler, contains the synchroniser, the bit-clock counter and the 3-tap majority voter. It outputs s_din, a sample_strobe and the voted bit value. The top level holds the FSM, shift register and error logic.

Test Plan:
- Defaults (8N1), 0x2A then 0x58 back-to-back at 8680.5 ns per bit, 31.25 ns clk -> two valid pulses with data_rx=0x2A and then 0x58, flags 0, the first pulse 2645±1 clocks after the falling edge.
- PARITY=2, DATA_BITS=7, STOP_BITS=2, send 0x41 with a correct parity bit, then 0x41 with a flipped parity bit -> valid with parity_err=0, then valid with parity_err=1 and data_rx=0x41.
- Defaults, 0x55 with the stop bit driven low -> valid with frame_err=1 and data_rx=0x55; brk stays 0.
- Line low for 15 bit times, then high -> valid with frame_err=1 and data_rx=0x00. brk rises with valid and falls 278 clocks after the line returns high. A following 0xA5 frame is received correctly.
- A low glitch of 60 clocks on an idle line -> no valid, busy returns to 0, and the next 0x3C frame is received correctly.
- rst pulsed low during bit 4 of 0xFF -> outputs 0 asynchronously and no valid for the aborted frame; a following 0x81 frame gives data_rx=0x81.
